// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: CPU clock divider with read wait-states, region decode,
// sticky per-device write flags and a latched decode-fault record.
module sys_bus_ctrl #(
   parameter int unsigned DIV      = 7,
   parameter int unsigned N_DEV    = 4,
   parameter int unsigned SEL_W    = 4,
   parameter logic [N_DEV*SEL_W-1:0] DEV_SEL = {4'hC, 4'hB, 4'hA, 4'h0},
   parameter logic [N_DEV-1:0] SLOW_MASK = '0,
   parameter int unsigned WAIT_CYC = 4,
   parameter int unsigned LED_DEV  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 cpu_clk,
   output logic                 cpu_rise,
   input  logic [31:0]          cpu_addr,
   input  logic [1:0]           cpu_memwrite,
   input  logic                 cpu_memread,
   output logic [2*N_DEV-1:0]   dev_write,
   output logic [N_DEV-1:0]     dev_read,
   output logic [31-SEL_W:0]    dev_addr,
   output logic [N_DEV-1:0]     wr_seen,
   input  logic [N_DEV-1:0]     flag_clr,
   output logic                 fault,
   output logic [31:0]          fault_addr,
   input  logic                 fault_clr,
   output logic                 led
);

   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int unsigned WC_W  = (WAIT_CYC > 2) ? $clog2(WAIT_CYC) : 1;

   typedef enum logic {
      ST_RUN,
      ST_WAIT
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WC_W-1:0]    wcnt_q, wcnt_d;
   logic               cpu_clk_q, cpu_clk_d;
   logic               cpu_rise_q, cpu_rise_d;
   logic [N_DEV-1:0]   wr_seen_q, wr_seen_d;
   logic               fault_q, fault_d;
   logic [31:0]        fault_addr_q, fault_addr_d;

   logic [SEL_W-1:0]   sel;
   logic [N_DEV-1:0]   hit_oh;
   logic               hit;
   logic               any_acc;
   logic               slow_rd;
   logic               fault_ev;

   assign sel = cpu_addr[31:32-SEL_W];

   // Lowest-index region match, then route strobes to that device only.
   always_comb begin
      hit       = 1'b0;
      hit_oh    = '0;
      dev_write = '0;
      dev_read  = '0;
      for (int i = 0; i < int'(N_DEV); i++) begin
         if (!hit && sel == DEV_SEL[i*SEL_W +: SEL_W]) begin
            hit       = 1'b1;
            hit_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < int'(N_DEV); i++) begin
         if (hit_oh[i]) begin
            dev_write[2*i +: 2] = cpu_memwrite;
            dev_read[i]         = cpu_memread;
         end
      end
   end

   assign dev_addr = cpu_addr[31-SEL_W:0];
   assign any_acc  = (cpu_memwrite != 2'b00) || cpu_memread;
   assign slow_rd  = cpu_memread && ((hit_oh & SLOW_MASK) != '0);
   assign fault_ev = cpu_rise_q && !hit && any_acc;

   // Divider FSM: a rise due during a slow read is deferred by WAIT_CYC clks.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wcnt_d     = wcnt_q;
      cpu_clk_d  = cpu_clk_q;
      cpu_rise_d = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
               cnt_d = '0;
               if (!cpu_clk_q && slow_rd) begin
                  state_d = ST_WAIT;
               end else begin
                  cpu_clk_d  = ~cpu_clk_q;
                  cpu_rise_d = ~cpu_clk_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (wcnt_q == WC_W'(WAIT_CYC - 1)) begin
               wcnt_d     = '0;
               cpu_clk_d  = 1'b1;
               cpu_rise_d = 1'b1;
               state_d    = ST_RUN;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Flags sample the bus once per CPU cycle; a set beats a same-cycle clear.
   always_comb begin
      wr_seen_d = wr_seen_q & ~flag_clr;
      if (cpu_rise_q && cpu_memwrite != 2'b00) begin
         wr_seen_d = wr_seen_d | hit_oh;
      end
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      if (fault_ev) begin
         fault_d = 1'b1;
         if (!fault_q || fault_clr) begin
            fault_addr_d = cpu_addr;
         end
      end else if (fault_clr) begin
         fault_d      = 1'b0;
         fault_addr_d = '0;
      end
   end

   // State and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         cnt_q        <= '0;
         wcnt_q       <= '0;
         cpu_clk_q    <= 1'b0;
         cpu_rise_q   <= 1'b0;
         wr_seen_q    <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wcnt_q       <= wcnt_d;
         cpu_clk_q    <= cpu_clk_d;
         cpu_rise_q   <= cpu_rise_d;
         wr_seen_q    <= wr_seen_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign cpu_clk    = cpu_clk_q;
   assign cpu_rise   = cpu_rise_q;
   assign wr_seen    = wr_seen_q;
   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;
   assign led        = wr_seen_q[LED_DEV];

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb_sys_bus_ctrl: randomized and directed checks of sys_bus_ctrl
// against a phase-length reference model.
module tb_sys_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_clk, cpu_rise;
   logic [31:0] cpu_addr;
   logic [1:0]  cpu_memwrite;
   logic        cpu_memread;
   logic [7:0]  dev_write;
   logic [3:0]  dev_read;
   logic [27:0] dev_addr;
   logic [3:0]  wr_seen;
   logic [3:0]  flag_clr;
   logic        fault;
   logic [31:0] fault_addr;
   logic        fault_clr;
   logic        led;

   int checks = 0;
   int errors = 0;

   sys_bus_ctrl #(.SLOW_MASK(4'b0100)) dut (
      .clk(clk), .rst(rst),
      .cpu_clk(cpu_clk), .cpu_rise(cpu_rise),
      .cpu_addr(cpu_addr), .cpu_memwrite(cpu_memwrite),
      .cpu_memread(cpu_memread),
      .dev_write(dev_write), .dev_read(dev_read), .dev_addr(dev_addr),
      .wr_seen(wr_seen), .flag_clr(flag_clr),
      .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr),
      .led(led)
   );

   always #5 clk = ~clk;

   // Region table in index order: device 0 = 0x0, 1 = 0xA, 2 = 0xB, 3 = 0xC.
   function automatic int ref_idx(input logic [31:0] a);
      logic [3:0] tab [4];
      tab[0] = 4'h0; tab[1] = 4'hA; tab[2] = 4'hB; tab[3] = 4'hC;
      for (int i = 0; i < 4; i++)
         if (a[31:28] == tab[i]) return i;
      return -1;
   endfunction

   // Reference: the CPU clock is a sequence of phases; a high phase lasts 7,
   // a low phase 7, or 11 if a device-2 read is pending when it would end.
   logic        m_clk, m_str, m_rise, m_f;
   logic [3:0]  m_ws;
   logic [31:0] m_fa;
   int          m_el;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_clk <= 0; m_str <= 0; m_rise <= 0; m_f <= 0;
         m_ws <= 0; m_fa <= 0; m_el <= 0;
      end else begin
         int idx, el, len;
         logic [3:0] ws;
         idx = ref_idx(cpu_addr);
         ws = m_ws & ~flag_clr;
         if (m_rise && idx >= 0 && cpu_memwrite != 0) ws[idx] = 1'b1;
         m_ws <= ws;
         if (m_rise && idx < 0 && (cpu_memwrite != 0 || cpu_memread)) begin
            m_f <= 1;
            if (!m_f || fault_clr) m_fa <= cpu_addr;
         end else if (fault_clr) begin
            m_f <= 0; m_fa <= 0;
         end
         el = m_el + 1;
         len = m_clk ? 7 : (m_str ? 11 : 7);
         if (!m_clk && !m_str && el == 7 && cpu_memread && idx == 2) begin
            m_str <= 1; m_el <= el; m_rise <= 0;
         end else if (el == len) begin
            m_clk <= !m_clk; m_el <= 0; m_str <= 0; m_rise <= !m_clk;
         end else begin
            m_el <= el; m_rise <= 0;
         end
      end
   end

   task automatic wait_rise(output bit ok);
      ok = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (cpu_rise) begin ok = 1; return; end
      end
   endtask

   task automatic idle_clear();
      cpu_memwrite = 0; cpu_memread = 0; cpu_addr = 0;
      flag_clr = 4'hF; fault_clr = 1;
      @(negedge clk);
      while (cpu_rise) @(negedge clk);
      flag_clr = 0; fault_clr = 0;
   endtask

   task automatic test_reset();
      rst = 1; cpu_addr = 0; cpu_memwrite = 0; cpu_memread = 0;
      flag_clr = 0; fault_clr = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cpu_clk, cpu_rise, wr_seen, fault, fault_addr, led,
           dev_write, dev_read} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got clk=%b rise=%b ws=%h f=%b fa=%h led=%b dw=%h dr=%h want all 0",
                  cpu_clk, cpu_rise, wr_seen, fault, fault_addr, led, dev_write, dev_read);
      end
      rst = 0;
   endtask

   task automatic test_clock();
      int last = -1, hi = 0, lo = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         checks++;
         if (cpu_clk !== m_clk || cpu_rise !== m_rise) begin
            errors++;
            $display("FAIL clock_model c=%0d got clk=%b rise=%b want clk=%b rise=%b",
                     c, cpu_clk, cpu_rise, m_clk, m_rise);
         end
         if (cpu_clk) hi++; else lo++;
         if (cpu_rise) begin
            if (last >= 0) begin
               checks++;
               if (c - last != 14) begin
                  errors++;
                  $display("FAIL rise_period got %0d want 14", c - last);
               end
            end
            last = c;
         end
      end
      checks++;
      if (hi < 28 || hi > 32 || lo < 28 || lo > 32) begin
         errors++;
         $display("FAIL duty got hi=%0d lo=%0d want ~30 each", hi, lo);
      end
   endtask

   task automatic test_random();
      logic [3:0] pick [8];
      pick[0] = 4'h0; pick[1] = 4'hA; pick[2] = 4'hB; pick[3] = 4'hC;
      pick[4] = 4'h5; pick[5] = 4'h6; pick[6] = 4'hF; pick[7] = 4'h1;
      for (int c = 0; c < 300; c++) begin
         int idx;
         logic [7:0] ew;
         logic [3:0] er;
         cpu_addr = {pick[$urandom_range(7)], 28'($urandom)};
         cpu_memwrite = 2'($urandom);
         cpu_memread = ($urandom_range(3) == 0);
         flag_clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
         fault_clr = ($urandom_range(9) == 0);
         #1;
         idx = ref_idx(cpu_addr);
         ew = 0; er = 0;
         if (idx >= 0) begin
            ew[2*idx +: 2] = cpu_memwrite;
            er[idx] = cpu_memread;
         end
         checks++;
         if (dev_write !== ew || dev_read !== er || dev_addr !== cpu_addr[27:0]) begin
            errors++;
            $display("FAIL decode a=%h got dw=%h dr=%h da=%h want dw=%h dr=%h da=%h",
                     cpu_addr, dev_write, dev_read, dev_addr, ew, er, cpu_addr[27:0]);
         end
         @(negedge clk);
         checks++;
         if (cpu_clk !== m_clk || cpu_rise !== m_rise || wr_seen !== m_ws ||
             fault !== m_f || fault_addr !== m_fa || led !== m_ws[0]) begin
            errors++;
            $display("FAIL rand_state c=%0d got clk=%b rise=%b ws=%h f=%b fa=%h led=%b want %b %b %h %b %h %b",
                     c, cpu_clk, cpu_rise, wr_seen, fault, fault_addr, led,
                     m_clk, m_rise, m_ws, m_f, m_fa, m_ws[0]);
         end
      end
      idle_clear();
   endtask

   task automatic test_write_flag();
      bit ok;
      idle_clear();
      cpu_addr = 32'hA000_0010; cpu_memwrite = 2'b01;
      #1;
      checks++;
      if (dev_write !== 8'b0000_0100 || dev_read !== 4'b0 || dev_addr !== 28'h000_0010) begin
         errors++;
         $display("FAIL wr_decode got dw=%b dr=%b da=%h want 00000100 0000 0000010",
                  dev_write, dev_read, dev_addr);
      end
      wait_rise(ok);
      @(negedge clk);
      checks++;
      if (!ok || wr_seen !== 4'b0010 || led !== 1'b0) begin
         errors++;
         $display("FAIL wr_seen ok=%0d got ws=%b led=%b want 0010 0", ok, wr_seen, led);
      end
   endtask

   task automatic test_set_wins();
      bit ok;
      idle_clear();
      cpu_addr = 32'h0000_0040; cpu_memwrite = 2'b11;
      wait_rise(ok);
      flag_clr = 4'b0001;
      @(negedge clk);
      checks++;
      if (!ok || wr_seen[0] !== 1'b1 || led !== 1'b1) begin
         errors++;
         $display("FAIL set_wins ok=%0d got ws0=%b led=%b want 1 1", ok, wr_seen[0], led);
      end
      cpu_memwrite = 0;
      @(negedge clk);
      checks++;
      if (wr_seen[0] !== 1'b0 || led !== 1'b0) begin
         errors++;
         $display("FAIL clr_after got ws0=%b led=%b want 0 0", wr_seen[0], led);
      end
      flag_clr = 0;
   endtask

   task automatic test_slow();
      bit ok;
      idle_clear();
      cpu_addr = 32'hB000_0000; cpu_memread = 1;
      wait_rise(ok);
      for (int k = 0; k < 2; k++) begin
         int hi = 1, lo = 0, rises = 1, n = 0;
         while (n < 40) begin
            @(negedge clk); n++;
            if (cpu_clk) begin
               if (lo > 0) break;
               hi++;
            end else lo++;
            if (cpu_rise) rises++;
         end
         checks++;
         if (!ok || hi != 7 || lo != 11 || rises != 1 || !cpu_rise) begin
            errors++;
            $display("FAIL slow_phase k=%0d ok=%0d got hi=%0d lo=%0d rises=%0d want 7 11 1",
                     k, ok, hi, lo, rises);
         end
      end
      cpu_memread = 0;
   endtask

   task automatic test_fault();
      bit ok1, ok2, ok3, ok4;
      idle_clear();
      cpu_addr = 32'h5000_0004; cpu_memwrite = 2'b01;
      wait_rise(ok1);
      @(negedge clk);
      cpu_addr = 32'h6000_0008;
      wait_rise(ok2);
      @(negedge clk);
      checks++;
      if (!ok1 || !ok2 || fault !== 1'b1 || fault_addr !== 32'h5000_0004) begin
         errors++;
         $display("FAIL fault_keep ok=%0d%0d got f=%b fa=%h want 1 50000004",
                  ok1, ok2, fault, fault_addr);
      end
      cpu_memwrite = 0; fault_clr = 1;
      @(negedge clk);
      fault_clr = 0;
      checks++;
      if (fault !== 1'b0 || fault_addr !== 32'h0) begin
         errors++;
         $display("FAIL fault_clr got f=%b fa=%h want 0 0", fault, fault_addr);
      end
      cpu_addr = 32'h6000_0008; cpu_memwrite = 2'b10;
      wait_rise(ok3);
      @(negedge clk);
      cpu_addr = 32'h7000_0000;
      wait_rise(ok4);
      fault_clr = 1;
      @(negedge clk);
      fault_clr = 0; cpu_memwrite = 0;
      checks++;
      if (!ok3 || !ok4 || fault !== 1'b1 || fault_addr !== 32'h7000_0000) begin
         errors++;
         $display("FAIL fault_clr_new ok=%0d%0d got f=%b fa=%h want 1 70000000",
                  ok3, ok4, fault, fault_addr);
      end
   endtask

   task automatic test_reset_wait();
      bit seen = 0;
      int n = 0;
      idle_clear();
      cpu_addr = 32'hB000_0000; cpu_memread = 1;
      for (int c = 0; c < 40 && !seen; c++) begin
         logic prev;
         prev = cpu_clk;
         @(negedge clk);
         if (prev && !cpu_clk) seen = 1;
      end
      repeat (9) @(negedge clk);
      checks++;
      if (!seen || cpu_clk !== 1'b0 || m_str !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst_wait seen=%0d got clk=%b want 0 (stretched=%b)",
                  seen, cpu_clk, m_str);
      end
      rst = 1;
      #1;
      checks++;
      if (cpu_clk !== 1'b0 || cpu_rise !== 1'b0) begin
         errors++;
         $display("FAIL rst_in_wait got clk=%b rise=%b want 0 0", cpu_clk, cpu_rise);
      end
      repeat (2) @(negedge clk);
      rst = 0; cpu_memread = 0;
      do begin
         @(negedge clk); n++;
      end while (!cpu_clk && n < 30);
      checks++;
      if (n != 7 || !cpu_rise) begin
         errors++;
         $display("FAIL rise_after_rst got %0d clks rise=%b want 7 1", n, cpu_rise);
      end
   endtask

   initial begin
      test_reset();
      test_clock();
      test_random();
      test_write_flag();
      test_set_wins();
      test_slow();
      test_fault();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
